// File: rtl/fsm_esteira_multi_if.sv
// Handshake/status bundle between the master sequencer, the station sensors and the belt motor FSM.
// Latency: none, plain wires.
// Backpressure: none; cmd_mover is a level request held by the master until completion is seen.
// Optional: FSM_ESTEIRA_CICLOS_EN adds the ciclos_ultimo status bus.
interface fsm_esteira_multi_if #(
  parameter int N_DEST = 3,
  parameter int DW     = 2,
  parameter int CW     = 28
);
  // master sequencer / station side
  logic              cmd_mover;
  logic [DW-1:0]     destino;
  logic [N_DEST-1:0] sensores;
  logic              alarme_rolha;
  logic              limpar_falha;
  // FSM side
  logic              motor_ativo;
  logic              tarefa_concluida;
  logic              falha_timeout;
  logic              ocupado;
  logic [DW-1:0]     destino_atual;
`ifdef FSM_ESTEIRA_CICLOS_EN
  logic [CW-1:0]     ciclos_ultimo;

  modport master (
    output cmd_mover, destino, sensores, alarme_rolha, limpar_falha,
    input  motor_ativo, tarefa_concluida, falha_timeout, ocupado, destino_atual, ciclos_ultimo
  );

  modport slave (
    input  cmd_mover, destino, sensores, alarme_rolha, limpar_falha,
    output motor_ativo, tarefa_concluida, falha_timeout, ocupado, destino_atual, ciclos_ultimo
  );
`else
  modport master (
    output cmd_mover, destino, sensores, alarme_rolha, limpar_falha,
    input  motor_ativo, tarefa_concluida, falha_timeout, ocupado, destino_atual
  );

  modport slave (
    input  cmd_mover, destino, sensores, alarme_rolha, limpar_falha,
    output motor_ativo, tarefa_concluida, falha_timeout, ocupado, destino_atual
  );
`endif
endinterface

// File: rtl/fsm_esteira_multi.sv
// Multi-station conveyor motor FSM: moves the belt to the station picked per command, with pause/abort/timeout.
// Latency: motor_ativo is Mealy (drops the same cycle the target sensor or alarm rises); state moves 1 cycle after inputs.
// Backpressure: cmd_mover is a level handshake; completion/fault is held until the master drops cmd_mover.
// Optional: define FSM_ESTEIRA_CICLOS_EN to add ciclos_ultimo (motor-on cycles of the last completed move).
module fsm_esteira_multi #(
  parameter int N_DEST         = 3,
  parameter int DW             = 2,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int CW             = 28
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  fsm_esteira_multi_if.slave    io_bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVENDO = 3'd1,
    S_PAUSADO = 3'd2,
    S_PARADO  = 3'd3,
    S_FALHA   = 3'd4
  } state_t;

  // Destination range check is done one bit wider so N_DEST == 2**DW still fits.
  localparam logic [DW:0]   N_DEST_W = (DW+1)'(N_DEST);
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST  = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        r_state;
  state_t        w_next_state;
  logic [DW-1:0] r_dest;
  logic [DW-1:0] w_next_dest;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;

  logic          w_alvo;
  logic          w_dest_ok;
  logic          w_dest_sens;
  logic          w_start;
  logic          w_timeout_hit;
  logic [CW-1:0] w_cnt_inc;

`ifdef FSM_ESTEIRA_CICLOS_EN
  logic [CW-1:0] r_ciclos;
  logic [CW-1:0] w_next_ciclos;
`endif

  // Input decode shared by the next-state logic and the Mealy motor output.
  always_comb begin
    w_alvo        = io_bus.sensores[r_dest];
    w_dest_ok     = ({1'b0, io_bus.destino} < N_DEST_W);
    // Only look at the requested sensor when the index is legal.
    w_dest_sens   = w_dest_ok && io_bus.sensores[io_bus.destino];
    w_start       = io_bus.cmd_mover && !io_bus.alarme_rolha && w_dest_ok;
    w_timeout_hit = TO_EN && (r_cnt == TO_LAST);
    // The counter saturates instead of wrapping, so a disabled timeout never aliases back to zero.
    w_cnt_inc     = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CW'(1));
  end

  // State, latched target and travel counter registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_dest  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_dest  <= w_next_dest;
      r_cnt   <= w_next_cnt;
    end
  end

`ifdef FSM_ESTEIRA_CICLOS_EN
  // Snapshot of the travel counter taken on each completed move.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ciclos <= '0;
    end else begin
      r_ciclos <= w_next_ciclos;
    end
  end
`endif

  // Next-state, counter and target update; priority order inside each state matters.
  always_comb begin
    w_next_state = r_state;
    w_next_dest  = r_dest;
    w_next_cnt   = r_cnt;
`ifdef FSM_ESTEIRA_CICLOS_EN
    w_next_ciclos = r_ciclos;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_dest  = io_bus.destino;
          w_next_cnt   = '0;
          // Belt already parked at the target: complete without ever starting the motor.
          w_next_state = w_dest_sens ? S_PARADO : S_MOVENDO;
        end
      end
      S_MOVENDO: begin
        if (w_alvo) begin
          w_next_state = S_PARADO;
`ifdef FSM_ESTEIRA_CICLOS_EN
          w_next_ciclos = r_cnt;
`endif
        end else if (io_bus.alarme_rolha) begin
          w_next_state = S_PAUSADO;
        end else if (!io_bus.cmd_mover) begin
          w_next_state = S_IDLE;
        end else if (w_timeout_hit) begin
          w_next_state = S_FALHA;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      S_PAUSADO: begin
        // Counter is frozen here: only motor-on time counts toward the timeout.
        if (w_alvo) begin
          w_next_state = S_PARADO;
`ifdef FSM_ESTEIRA_CICLOS_EN
          w_next_ciclos = r_cnt;
`endif
        end else if (!io_bus.cmd_mover) begin
          w_next_state = S_IDLE;
        end else if (!io_bus.alarme_rolha) begin
          w_next_state = S_MOVENDO;
        end
      end
      S_PARADO: begin
        if (!io_bus.cmd_mover) begin
          w_next_state = S_IDLE;
        end
      end
      S_FALHA: begin
        // Clearing requires the master to have withdrawn the command, so a fault cannot auto-retry.
        if (io_bus.limpar_falha && !io_bus.cmd_mover) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the current state; motor is Mealy on the target sensor and alarm.
  always_comb begin
    io_bus.motor_ativo      = 1'b0;
    io_bus.tarefa_concluida = 1'b0;
    io_bus.falha_timeout    = 1'b0;
    io_bus.ocupado          = 1'b0;
    io_bus.destino_atual    = r_dest;
    case (r_state)
      S_MOVENDO: begin
        // Reset gating makes the motor stop in the very cycle reset is sampled.
        io_bus.motor_ativo = i_reset && !w_alvo && !io_bus.alarme_rolha;
        io_bus.ocupado     = 1'b1;
      end
      S_PAUSADO: begin
        io_bus.ocupado = 1'b1;
      end
      S_PARADO: begin
        io_bus.tarefa_concluida = 1'b1;
      end
      S_FALHA: begin
        io_bus.falha_timeout = 1'b1;
      end
      default: begin
        io_bus.ocupado = 1'b0;
      end
    endcase
  end

`ifdef FSM_ESTEIRA_CICLOS_EN
  assign io_bus.ciclos_ultimo = r_ciclos;
`endif

endmodule

// File: tb/tb_fsm_esteira_multi.sv
// Scoreboard bench for fsm_esteira_multi: directed scenarios followed by randomized traffic.
// Latency: expected outputs for each cycle are queued at drive time and compared at the following negedge.
// Backpressure: none; the monitor drains one expectation per cycle.
module tb_fsm_esteira_multi;

  localparam int N_DEST = 3;
  localparam int DW     = 2;
  localparam int TO     = 8;
  localparam int CW     = 4;

  logic clk;
  logic rst;

  fsm_esteira_multi_if #(.N_DEST(N_DEST), .DW(DW), .CW(CW)) bus ();

  fsm_esteira_multi #(
    .N_DEST(N_DEST), .DW(DW), .TIMEOUT_CYCLES(TO), .CW(CW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int motor;
    int concl;
    int falha;
    int ocup;
    int dest;
    int ciclos;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc_no = 0;

  // Reference model: where the belt job is, in plain terms.
  typedef enum int {J_FREE, J_RUN, J_HOLD, J_DONE, J_ERR} job_t;
  job_t m_job = J_FREE;
  int   m_tgt = 0;
  int   m_on = 0;     // motor-on cycles accumulated in current move
  int   m_last = 0;   // on-cycles of the last finished move
  bit   m_known = 0;

  task automatic check(input string name, input int got, input int want, input int cyc);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, got, want);
  endtask

  // Monitor: pops one expectation per cycle and compares at the negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("motor_ativo",      int'(bus.motor_ativo),      e.motor, e.cyc);
      check("tarefa_concluida", int'(bus.tarefa_concluida), e.concl, e.cyc);
      check("falha_timeout",    int'(bus.falha_timeout),    e.falha, e.cyc);
      check("ocupado",          int'(bus.ocupado),          e.ocup,  e.cyc);
      check("destino_atual",    int'(bus.destino_atual),    e.dest,  e.cyc);
`ifdef FSM_ESTEIRA_CICLOS_EN
      check("ciclos_ultimo",    int'(bus.ciclos_ultimo),    e.ciclos, e.cyc);
`endif
    end
  end

  // Drive one cycle of inputs, queue what the outputs must be, then advance the model across the edge.
  task automatic step(input bit r, input bit cmd, input int dst, input bit [2:0] sens,
                      input bit alarm, input bit clr);
    exp_t e;
    bit at_tgt;
    @(posedge clk);
    #1;
    cyc_no++;
    rst                 = r;
    bus.cmd_mover       = cmd;
    bus.destino         = DW'(dst);
    bus.sensores        = sens;
    bus.alarme_rolha    = alarm;
    bus.limpar_falha    = clr;

    at_tgt = sens[m_tgt];
    if (m_known) begin
      e.motor  = (r && m_job == J_RUN && !at_tgt && !alarm) ? 1 : 0;
      e.concl  = (m_job == J_DONE) ? 1 : 0;
      e.falha  = (m_job == J_ERR) ? 1 : 0;
      e.ocup   = (m_job == J_RUN || m_job == J_HOLD) ? 1 : 0;
      e.dest   = m_tgt;
      e.ciclos = m_last;
      e.cyc    = cyc_no;
      exp_q.push_back(e);
    end

    if (!r) begin
      m_job = J_FREE; m_tgt = 0; m_on = 0; m_last = 0; m_known = 1;
    end else begin
      case (m_job)
        J_FREE:
          if (cmd && !alarm && dst < N_DEST) begin
            m_tgt = dst;
            m_on  = 0;
            m_job = sens[dst] ? J_DONE : J_RUN;
          end
        J_RUN:
          if (at_tgt) begin m_job = J_DONE; m_last = m_on; end
          else if (alarm) m_job = J_HOLD;
          else if (!cmd) m_job = J_FREE;
          else if (TO != 0 && m_on + 1 >= TO) m_job = J_ERR;
          else if (m_on < (1 << CW) - 1) m_on = m_on + 1;
        J_HOLD:
          if (at_tgt) begin m_job = J_DONE; m_last = m_on; end
          else if (!cmd) m_job = J_FREE;
          else if (!alarm) m_job = J_RUN;
        J_DONE:
          if (!cmd) m_job = J_FREE;
        J_ERR:
          if (clr && !cmd) m_job = J_FREE;
        default: m_job = J_FREE;
      endcase
    end
  endtask

  initial begin
    bit cmd_r;
    rst = 1'b0;
    bus.cmd_mover = 1'b0; bus.destino = '0; bus.sensores = '0;
    bus.alarme_rolha = 1'b0; bus.limpar_falha = 1'b0;

    // Reset and idle outputs
    repeat (3) step(0, 0, 0, 3'b000, 0, 0);
    step(1, 0, 0, 3'b000, 0, 0);

    // Move to station 2, sensor arrives, master acknowledges
    repeat (4) step(1, 1, 2, 3'b000, 0, 0);
    repeat (2) step(1, 1, 2, 3'b100, 0, 0);
    repeat (2) step(1, 0, 2, 3'b000, 0, 0);

    // Move to 1 with a foreign sensor pulse
    repeat (2) step(1, 1, 1, 3'b000, 0, 0);
    step(1, 1, 1, 3'b001, 0, 0);
    step(1, 1, 1, 3'b000, 0, 0);
    // Alarm for 5 cycles, then resume and finish
    repeat (5) step(1, 1, 1, 3'b000, 1, 0);
    repeat (3) step(1, 1, 1, 3'b000, 0, 0);
    step(1, 1, 1, 3'b010, 0, 0);
    repeat (2) step(1, 0, 0, 3'b000, 0, 0);

    // Timeout toward station 0, blocked clear, real clear
    repeat (11) step(1, 1, 0, 3'b000, 0, 0);
    repeat (2) step(1, 1, 0, 3'b000, 0, 1);
    step(1, 0, 0, 3'b000, 0, 0);
    repeat (2) step(1, 0, 0, 3'b000, 0, 1);

    // Already at target, then illegal destination
    repeat (3) step(1, 1, 1, 3'b010, 0, 0);
    step(1, 0, 1, 3'b000, 0, 0);
    repeat (3) step(1, 1, 3, 3'b111, 0, 0);
    step(1, 0, 0, 3'b000, 0, 0);

    // Six motor-on cycles then arrival
    step(1, 1, 2, 3'b000, 0, 0);
    repeat (6) step(1, 1, 2, 3'b000, 0, 0);
    repeat (2) step(1, 1, 2, 3'b100, 0, 0);
    step(1, 0, 2, 3'b000, 0, 0);

    // Reset while moving
    repeat (3) step(1, 1, 1, 3'b000, 0, 0);
    step(0, 1, 1, 3'b000, 0, 0);
    step(1, 0, 0, 3'b000, 0, 0);

    // Randomized traffic
    cmd_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit [2:0] s;
      if ($urandom_range(9) == 0) cmd_r = ~cmd_r;
      for (int b = 0; b < 3; b++) s[b] = ($urandom_range(5) == 0);
      step(($urandom_range(99) != 0), cmd_r, int'($urandom_range(3)), s,
           ($urandom_range(9) == 0), ($urandom_range(7) == 0));
    end

    // Let the monitor drain, bounded
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    if (n_total < 12) begin
      n_total++;
      $display("FAIL check_count got %0d want at least 12", n_total);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
